// File: rtl/sobel_pipe.sv
// Three-stage pipelined 3x3 gradient engine (Sobel/Prewitt, L1/max norm, threshold, edge counter).
// Optional quantised direction output grad_dir is built only when SOBEL_DIR_EN is defined.
module sobel_pipe #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] p3,
  input  logic [PIX_W-1:0] p4,
  input  logic [PIX_W-1:0] p5,
  input  logic [PIX_W-1:0] p6,
  input  logic [PIX_W-1:0] p7,
  input  logic [PIX_W-1:0] p8,
  input  logic [PIX_W-1:0] p9,
  input  logic             mode,
  input  logic             norm,
  input  logic             bin_en,
  input  logic [PIX_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] edge_pixel,
  output logic [PIX_W+3:0] grad_mag,
  output logic             is_edge,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] edge_cnt
`ifdef SOBEL_DIR_EN
  ,
  output logic [1:0]       grad_dir
`endif
);

  localparam int SW = PIX_W + 3;
  localparam int AW = PIX_W + 2;

  function automatic logic [SW-1:0] z(input logic [PIX_W-1:0] v);
    z = {3'b000, v};
  endfunction

  // Centre-row/column tap: weight 2 for Sobel, 1 for Prewitt.
  function automatic logic [SW-1:0] wt(input logic [PIX_W-1:0] v, input logic prewitt);
    wt = prewitt ? {3'b000, v} : {2'b00, v, 1'b0};
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // The window centre does not contribute to either gradient.
  logic unused_p5;
  assign unused_p5 = ^p5;

  // S1
  logic [SW-1:0]        pos_x, neg_x, pos_y, neg_y;
  logic signed [SW-1:0] gx_c, gy_c;

  always_comb begin
    pos_x = z(p3) + wt(p6, mode) + z(p9);
    neg_x = z(p1) + wt(p4, mode) + z(p7);
    pos_y = z(p1) + wt(p2, mode) + z(p3);
    neg_y = z(p7) + wt(p8, mode) + z(p9);
    gx_c  = signed'(pos_x - neg_x);
    gy_c  = signed'(pos_y - neg_y);
  end

  logic                 s1_valid, s1_norm, s1_bin;
  logic signed [SW-1:0] s1_gx, s1_gy;
  logic [PIX_W-1:0]     s1_thresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_gx     <= '0;
      s1_gy     <= '0;
      s1_norm   <= 1'b0;
      s1_bin    <= 1'b0;
      s1_thresh <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_gx     <= gx_c;
      s1_gy     <= gy_c;
      s1_norm   <= norm;
      s1_bin    <= bin_en;
      s1_thresh <= thresh;
    end
  end

  // S2
  logic [AW-1:0] ax, ay;
  logic [SW-1:0] mag_c;

  always_comb begin
    ax    = s1_gx[SW-1] ? AW'(-s1_gx) : AW'(s1_gx);
    ay    = s1_gy[SW-1] ? AW'(-s1_gy) : AW'(s1_gy);
    mag_c = {1'b0, ax} + {1'b0, ay};
    if (s1_norm)
      mag_c = (ax >= ay) ? {1'b0, ax} : {1'b0, ay};
  end

  logic             s2_valid, s2_bin;
  logic [SW-1:0]    s2_mag;
  logic [PIX_W-1:0] s2_thresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_mag    <= '0;
      s2_bin    <= 1'b0;
      s2_thresh <= '0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_mag    <= mag_c;
      s2_bin    <= s1_bin;
      s2_thresh <= s1_thresh;
    end
  end

`ifdef SOBEL_DIR_EN
  // Zero gradient falls into the first branch and reports 0.
  logic [1:0] dir_c;
  logic [1:0] s2_dir;

  always_comb begin
    dir_c = 2'd0;
    if ({1'b0, ax} >= {ay, 1'b0})
      dir_c = 2'd0;
    else if ({1'b0, ay} >= {ax, 1'b0})
      dir_c = 2'd2;
    else if (s1_gx[SW-1] == s1_gy[SW-1])
      dir_c = 2'd1;
    else
      dir_c = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_dir   <= 2'd0;
      grad_dir <= 2'd0;
    end else if (adv) begin
      s2_dir   <= dir_c;
      grad_dir <= s2_dir;
    end
  end
`endif

  // S3
  logic             edge_c;
  logic [PIX_W-1:0] pix_c;

  always_comb begin
    edge_c = (s2_mag >= {3'b000, s2_thresh});
    if (s2_bin)
      pix_c = edge_c ? {PIX_W{1'b1}} : '0;
    else if (s2_mag >= {3'b000, {PIX_W{1'b1}}})
      pix_c = {PIX_W{1'b1}};
    else
      pix_c = s2_mag[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      grad_mag   <= '0;
      is_edge    <= 1'b0;
      edge_pixel <= '0;
    end else if (adv) begin
      out_valid  <= s2_valid;
      grad_mag   <= {1'b0, s2_mag};
      is_edge    <= edge_c;
      edge_pixel <= pix_c;
    end
  end

  // Clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      edge_cnt <= '0;
    else if (out_valid && out_ready && is_edge && (edge_cnt != {CNT_W{1'b1}}))
      edge_cnt <= edge_cnt + CNT_W'(1);
  end

endmodule
